// File: rtl/sim_pkg.sv
// Shared state encoding and default parameter constants for the cloth-chain
// constraint scheduler.
package sim_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VERLET = 3'd1,
        S_PIN    = 3'd2,
        S_RD     = 3'd3,
        S_WR     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int DEF_NUM_NODES  = 8;
    localparam int DEF_ITERATIONS = 3;
    localparam int DEF_W          = 8;
    localparam int DEF_REST_LEN   = 16;
    localparam int DEF_BASE_X     = 200;

endpackage

// File: rtl/pair_correct.sv
// Combinational position correction for one adjacent node pair: x pulled halfway
// toward the upper node, y limited to REST_LEN below it.
module pair_correct #(
    parameter int W        = 8,
    parameter int REST_LEN = 16
) (
    input  logic [W-1:0] i_x0,
    input  logic [W-1:0] i_x1,
    input  logic [W-1:0] i_y0,
    input  logic [W-1:0] i_y1,
    output logic [W-1:0] o_x,
    output logic [W-1:0] o_y,
    output logic         o_clamp
);

    logic signed [W:0] w_dx;
    logic signed [W:0] w_sum;
    logic        [W:0] w_lim;
    logic              w_unused_sign;

    assign w_dx  = $signed({1'b0, i_x0}) - $signed({1'b0, i_x1});
    assign w_sum = $signed({1'b0, i_x1}) + (w_dx >>> 1);
    assign o_x   = w_sum[W-1:0];
    // Result always lies between the two inputs, so the sign bit carries nothing.
    assign w_unused_sign = w_sum[W];

    // One extra bit so y0 + REST_LEN cannot wrap before the compare.
    assign w_lim   = {1'b0, i_y0} + (W+1)'(REST_LEN);
    assign o_clamp = ({1'b0, i_y1} > w_lim);
    assign o_y     = !o_clamp ? i_y1 : (w_lim[W] ? '1 : w_lim[W-1:0]);

endmodule

// File: rtl/constraint_scheduler.sv
// Frame sequencer for a pinned node chain: Verlet strobe, then ITERATIONS passes
// of pin + pairwise distance correction. Optional stats ports under SIM_STATS_EN.
module constraint_scheduler
    import sim_pkg::*;
#(
    parameter int NUM_NODES  = DEF_NUM_NODES,
    parameter int ITERATIONS = DEF_ITERATIONS,
    parameter int W          = DEF_W,
    parameter int REST_LEN   = DEF_REST_LEN,
    parameter int BASE_X     = DEF_BASE_X,
    localparam int SW        = $clog2(NUM_NODES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    output logic          busy,
    output logic          frame_done,
    output logic          verlet_state,
    output logic          fix_constraint_state,
    output logic [SW-1:0] node_sel,
    input  logic [W-1:0]  rd_x0,
    input  logic [W-1:0]  rd_y0,
    input  logic [W-1:0]  rd_x1,
    input  logic [W-1:0]  rd_y1,
    output logic          wr_en,
    output logic [SW-1:0] wr_idx,
    output logic [W-1:0]  wr_x,
    output logic [W-1:0]  wr_y
`ifdef SIM_STATS_EN
    ,
    output logic [15:0]   frame_count,
    output logic [15:0]   clamp_count
`endif
);

    localparam logic [SW-1:0] LAST_PAIR = SW'(NUM_NODES - 2);
    localparam logic [3:0]    ITER_C    = 4'(ITERATIONS);

    state_t        r_state, w_nxt;
    logic [SW-1:0] r_pair, w_pair_nxt;
    logic [3:0]    r_pass, w_pass_nxt;

    logic          r_busy, r_done, r_verlet, r_fix, r_wr_en;
    logic [SW-1:0] r_node_sel, r_wr_idx;

    logic [W-1:0]  w_cx, w_cy;
    logic          w_clamp;

    pair_correct #(
        .W        (W),
        .REST_LEN (REST_LEN)
    ) u_pair (
        .i_x0    (rd_x0),
        .i_x1    (rd_x1),
        .i_y0    (rd_y0),
        .i_y1    (rd_y1),
        .o_x     (w_cx),
        .o_y     (w_cy),
        .o_clamp (w_clamp)
    );

    always_comb begin
        w_nxt      = r_state;
        w_pair_nxt = r_pair;
        w_pass_nxt = r_pass;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_nxt      = S_VERLET;
                    w_pair_nxt = '0;
                    w_pass_nxt = '0;
                end
            end
            S_VERLET: begin
                w_nxt      = S_PIN;
                w_pass_nxt = 4'd1;
            end
            S_PIN: begin
                w_nxt      = S_RD;
                w_pair_nxt = '0;
            end
            S_RD: w_nxt = S_WR;
            S_WR: begin
                if (r_pair != LAST_PAIR) begin
                    w_nxt      = S_RD;
                    w_pair_nxt = r_pair + 1'b1;
                end else if (r_pass < ITER_C) begin
                    w_nxt      = S_PIN;
                    w_pass_nxt = r_pass + 4'd1;
                end else begin
                    w_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_nxt      = S_IDLE;
                w_pair_nxt = '0;
                w_pass_nxt = '0;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pair     <= '0;
            r_pass     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_verlet   <= 1'b0;
            r_fix      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_idx   <= '0;
            r_node_sel <= '0;
        end else begin
            r_state  <= w_nxt;
            r_pair   <= w_pair_nxt;
            r_pass   <= w_pass_nxt;
            r_busy   <= (w_nxt != S_IDLE);
            r_done   <= (w_nxt == S_DONE);
            r_verlet <= (w_nxt == S_VERLET);
            r_fix    <= (w_nxt == S_PIN) || (w_nxt == S_RD) || (w_nxt == S_WR);
            r_wr_en  <= (w_nxt == S_PIN) || (w_nxt == S_WR);
            r_wr_idx <= (w_nxt == S_WR) ? SW'(w_pair_nxt + 1'b1) : '0;
            if (w_nxt == S_RD)
                r_node_sel <= w_pair_nxt;
        end
    end

    assign busy                 = r_busy;
    assign frame_done           = r_done;
    assign verlet_state         = r_verlet;
    assign fix_constraint_state = r_fix;
    assign wr_en                = r_wr_en;
    assign wr_idx               = r_wr_idx;
    assign node_sel             = r_node_sel;

    // Pair data only arrives during WR, so the corrected value is decoded from the
    // registered state rather than captured a cycle ahead.
    assign wr_x = (r_state == S_WR)  ? w_cx :
                  (r_state == S_PIN) ? W'(BASE_X) : '0;
    assign wr_y = (r_state == S_WR)  ? w_cy : '0;

`ifdef SIM_STATS_EN
    logic [15:0] r_frame_cnt, r_clamp_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
            r_clamp_cnt <= '0;
        end else begin
            if (r_state == S_DONE)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if ((r_state == S_WR) && w_clamp && (r_clamp_cnt != 16'hFFFF))
                r_clamp_cnt <= r_clamp_cnt + 16'd1;
        end
    end

    assign frame_count = r_frame_cnt;
    assign clamp_count = r_clamp_cnt;
`else
    logic w_unused_clamp;
    assign w_unused_clamp = w_clamp;
`endif

endmodule

// File: tb/tb_constraint_scheduler.sv
// Randomized self-checking bench for constraint_scheduler against an array-level
// chain model; a second 2-node instance covers the minimum configuration.
module tb_constraint_scheduler;

    localparam int N  = 8;
    localparam int IT = 3;
    localparam int P  = 2 * N - 1;
    localparam int L  = 2 + IT * P;
    localparam int BX = 200;
    localparam int RL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, frame_start;
    logic       busy, frame_done, verlet_state, fix_cs, wr_en;
    logic [2:0] node_sel, wr_idx;
    logic [7:0] rd_x0, rd_y0, rd_x1, rd_y1, wr_x, wr_y;

    logic       f2_start, b2, d2, v2, fx2, we2;
    logic [0:0] ns2, wi2;
    logic [7:0] r2x0, r2y0, r2x1, r2y1, wx2, wy2;

`ifdef SIM_STATS_EN
    logic [15:0] frame_count, clamp_count, fc2, cc2;
`endif

    constraint_scheduler dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .verlet_state(verlet_state),
        .fix_constraint_state(fix_cs), .node_sel(node_sel),
        .rd_x0(rd_x0), .rd_y0(rd_y0), .rd_x1(rd_x1), .rd_y1(rd_y1),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y)
`ifdef SIM_STATS_EN
        , .frame_count(frame_count), .clamp_count(clamp_count)
`endif
    );

    constraint_scheduler #(.NUM_NODES(2), .ITERATIONS(1)) dut2 (
        .clk(clk), .reset(reset), .frame_start(f2_start), .busy(b2),
        .frame_done(d2), .verlet_state(v2), .fix_constraint_state(fx2),
        .node_sel(ns2), .rd_x0(r2x0), .rd_y0(r2y0), .rd_x1(r2x1), .rd_y1(r2y1),
        .wr_en(we2), .wr_idx(wi2), .wr_x(wx2), .wr_y(wy2)
`ifdef SIM_STATS_EN
        , .frame_count(fc2), .clamp_count(cc2)
`endif
    );

    logic [7:0] pa_x0, pa_x1, pa_y0, pa_y1, pa_x, pa_y;
    logic       pa_clamp;
    pair_correct #(.W(8), .REST_LEN(RL)) pc (
        .i_x0(pa_x0), .i_x1(pa_x1), .i_y0(pa_y0), .i_y1(pa_y1),
        .o_x(pa_x), .o_y(pa_y), .o_clamp(pa_clamp)
    );

    int checks = 0;
    int errors = 0;

    // Node memories answering node_sel one cycle later and absorbing writes.
    logic [7:0] mx[N], my[N], ld_x[N], ld_y[N];
    logic [7:0] m2x[2], m2y[2], ld2_x[2], ld2_y[2];
    logic       load_en;

    always @(posedge clk) begin
        if (load_en) begin
            for (int k = 0; k < N; k++) begin mx[k] <= ld_x[k]; my[k] <= ld_y[k]; end
            for (int k = 0; k < 2; k++) begin m2x[k] <= ld2_x[k]; m2y[k] <= ld2_y[k]; end
        end else begin
            if (wr_en) begin mx[wr_idx] <= wr_x; my[wr_idx] <= wr_y; end
            if (we2) begin m2x[wi2] <= wx2; m2y[wi2] <= wy2; end
        end
        rd_x0 <= mx[node_sel];
        rd_y0 <= my[node_sel];
        rd_x1 <= mx[int'(node_sel) + 1];
        rd_y1 <= my[int'(node_sel) + 1];
        r2x0  <= m2x[ns2];
        r2y0  <= m2y[ns2];
        r2x1  <= m2x[int'(ns2) + 1];
        r2y1  <= m2y[int'(ns2) + 1];
    end

    int ex[N], ey[N];
    int exp_frames, exp_clamp;
    bit cap_valid;
    logic [7:0] cap_x, cap_y;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Chain relaxation straight from the rules: pin node 0, then walk the pairs.
    function automatic int model(input int n, input int it);
        int cl = 0;
        for (int p = 0; p < it; p++) begin
            ex[0] = BX;
            ey[0] = 0;
            for (int i = 0; i < n - 1; i++) begin
                int d;
                d = ex[i] - ex[i+1];
                ex[i+1] = (ex[i+1] + (d >>> 1)) & 255;
                if (ey[i+1] > ey[i] + RL) begin
                    ey[i+1] = (ey[i] + RL > 255) ? 255 : ey[i] + RL;
                    cl++;
                end
            end
        end
        return cl;
    endfunction

    task automatic load_random();
        for (int k = 0; k < N; k++) begin
            ld_x[k] = 8'($urandom_range(0, 255));
            ld_y[k] = 8'($urandom_range(0, 255));
        end
        for (int k = 0; k < 2; k++) begin
            ld2_x[k] = 8'($urandom_range(0, 255));
            ld2_y[k] = 8'($urandom_range(0, 255));
        end
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic do_frame(input bit spurious);
        int  c, p;
        bit  seen, ev, ed, ef, ew;
        for (int k = 0; k < N; k++) begin ex[k] = int'(mx[k]); ey[k] = int'(my[k]); end
        exp_clamp += model(N, IT);
        if (exp_clamp > 65535) exp_clamp = 65535;
        exp_frames++;
        cap_valid   = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        c    = 1;
        seen = 1'b0;
        while (!seen && c <= L + 20) begin
            ev = (c == 1);
            ed = (c == L);
            ef = (c >= 2) && (c < L);
            p  = ef ? (c - 2) % P : 0;
            ew = ef && (p % 2 == 0);
            checks++;
            if ({busy, verlet_state, fix_cs, frame_done, wr_en} !== {1'b1, ev, ef, ed, ew}) begin
                errors++;
                $display("FAIL ctrl cycle %0d: got b/v/f/d/w=%b%b%b%b%b want %b%b%b%b%b", c,
                         busy, verlet_state, fix_cs, frame_done, wr_en, 1'b1, ev, ef, ed, ew);
            end
            if (ew) begin
                checks++;
                if (wr_idx !== 3'(p / 2)) begin
                    errors++;
                    $display("FAIL wr_idx cycle %0d: got %0d want %0d", c, wr_idx, p / 2);
                end
                if (p == 0) begin
                    checks++;
                    if ({wr_x, wr_y} !== {8'd200, 8'd0}) begin
                        errors++;
                        $display("FAIL pin cycle %0d: got (%0d,%0d) want (200,0)", c, wr_x, wr_y);
                    end
                end
            end
            if (ef && (p % 2 == 1)) begin
                checks++;
                if (node_sel !== 3'((p - 1) / 2)) begin
                    errors++;
                    $display("FAIL node_sel cycle %0d: got %0d want %0d", c, node_sel, (p - 1) / 2);
                end
            end
            if (wr_en && wr_idx == 3'd2 && !cap_valid) begin
                cap_valid = 1'b1;
                cap_x = wr_x;
                cap_y = wr_y;
            end
            frame_start = (spurious && c < L - 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (frame_done === 1'b1) seen = 1'b1;
            else begin cyc(); c++; end
        end
        frame_start = 1'b0;
        checks++;
        if (!seen || c != L) begin
            errors++;
            $display("FAIL frame_len: got %0d (done seen %0d) want %0d", c, seen, L);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL post_frame: busy=%b done=%b want 0 0", busy, frame_done);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (mx[k] !== 8'(ex[k]) || my[k] !== 8'(ey[k])) begin
                errors++;
                $display("FAIL node%0d: got (%0d,%0d) want (%0d,%0d)", k, mx[k], my[k], ex[k], ey[k]);
            end
        end
`ifdef SIM_STATS_EN
        checks++;
        if (frame_count !== 16'(exp_frames) || clamp_count !== 16'(exp_clamp)) begin
            errors++;
            $display("FAIL stats: got frames=%0d clamps=%0d want %0d %0d",
                     frame_count, clamp_count, exp_frames, exp_clamp);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_start = 1'b0; f2_start = 1'b0; load_en = 1'b0;
        pa_x0 = '0; pa_x1 = '0; pa_y0 = '0; pa_y1 = '0;
        for (int k = 0; k < N; k++) begin ld_x[k] = '0; ld_y[k] = '0; end
        for (int k = 0; k < 2; k++) begin ld2_x[k] = '0; ld2_y[k] = '0; end
        exp_frames = 0;
        exp_clamp  = 0;
        cyc(); cyc();
        checks++;
        if ({busy, frame_done, verlet_state, fix_cs, wr_en, node_sel, wr_idx, wr_x, wr_y} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got b%b d%b v%b f%b w%b ns%0d wi%0d x%0d y%0d want all 0",
                     busy, frame_done, verlet_state, fix_cs, wr_en, node_sel, wr_idx, wr_x, wr_y);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (busy !== 1'b0 || verlet_state !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: busy=%b verlet=%b want 0 0", busy, verlet_state);
            end
        end
    endtask

    task automatic test_arith();
        int x0, x1, y0, y1, wx, wy;
        bit cl;
        for (int v = 0; v < 27; v++) begin
            case (v)
                0:       begin x0 = 100; x1 = 120; y0 = 10;  y1 = 40;  end
                1:       begin x0 = 7;   x1 = 9;   y0 = 250; y1 = 255; end
                2:       begin x0 = 255; x1 = 0;   y0 = 245; y1 = 255; end
                default: begin
                    x0 = $urandom_range(0, 255); x1 = $urandom_range(0, 255);
                    y0 = $urandom_range(0, 255); y1 = $urandom_range(0, 255);
                end
            endcase
            pa_x0 = 8'(x0); pa_x1 = 8'(x1); pa_y0 = 8'(y0); pa_y1 = 8'(y1);
            #1;
            wx = (x1 + ((x0 - x1) >>> 1)) & 255;
            cl = (y1 > y0 + RL);
            wy = cl ? ((y0 + RL > 255) ? 255 : y0 + RL) : y1;
            checks++;
            if (pa_x !== 8'(wx) || pa_y !== 8'(wy) || pa_clamp !== cl) begin
                errors++;
                $display("FAIL pair_arith %0d/%0d/%0d/%0d: got (%0d,%0d,c%b) want (%0d,%0d,c%b)",
                         x0, x1, y0, y1, pa_x, pa_y, pa_clamp, wx, wy, cl);
            end
        end
    endtask

    task automatic test_frame_random();
        load_random();
        do_frame(1'b0);
    endtask

    task automatic test_directed_pair();
        load_random();
        ld_x[1] = 8'd0;   ld_y[1] = 8'd10;
        ld_x[2] = 8'd120; ld_y[2] = 8'd40;
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
        do_frame(1'b0);
        checks++;
        if (!cap_valid || cap_x !== 8'd110 || cap_y !== 8'd26) begin
            errors++;
            $display("FAIL directed_pair: got (%0d,%0d) valid %b want (110,26)", cap_x, cap_y, cap_valid);
        end
    endtask

    task automatic test_busy_ignore();
        load_random();
        do_frame(1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL extra_frame: done=%b busy=%b want 0 0", frame_done, busy);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int  pins = 0;
        bit  found = 1'b0;
        load_random();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int c = 1; c <= L + 5 && !found; c++) begin
            if (wr_en && wr_idx == 3'd0) pins++;
            if (wr_en && wr_idx != 3'd0 && pins == 2) found = 1'b1;
            else cyc();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL find_pass2_wr: got none want WR in pass 2");
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, verlet_state, fix_cs, wr_en, node_sel, wr_idx, wr_x, wr_y} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: got b%b d%b v%b f%b w%b ns%0d wi%0d x%0d y%0d want all 0",
                     busy, frame_done, verlet_state, fix_cs, wr_en, node_sel, wr_idx, wr_x, wr_y);
        end
        exp_frames = 0;
        exp_clamp  = 0;
        cyc(); cyc();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (busy !== 1'b0 || wr_en !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_release: busy=%b wr_en=%b want 0 0", busy, wr_en);
            end
        end
        do_frame(1'b0);
    endtask

    task automatic test_two_node();
        int  c = 1;
        bit  seen = 1'b0;
        load_random();
        ex[0] = int'(m2x[0]); ey[0] = int'(m2y[0]);
        ex[1] = int'(m2x[1]); ey[1] = int'(m2y[1]);
        void'(model(2, 1));
        f2_start = 1'b1;
        cyc();
        f2_start = 1'b0;
        while (!seen && c <= 20) begin
            checks++;
            if ({b2, v2, fx2, d2, we2} !== {1'b1, c == 1, c >= 2 && c <= 4, c == 5, c == 2 || c == 4}) begin
                errors++;
                $display("FAIL two_node cycle %0d: got b/v/f/d/w=%b%b%b%b%b", c, b2, v2, fx2, d2, we2);
            end
            if ((c == 3 && ns2 !== 1'b0) || (c == 4 && wi2 !== 1'b1) || (c == 2 && wi2 !== 1'b0)) begin
                errors++;
                $display("FAIL two_node_idx cycle %0d: got ns%0d wi%0d", c, ns2, wi2);
            end
            if (d2 === 1'b1) seen = 1'b1;
            else begin cyc(); c++; end
        end
        checks++;
        if (!seen || c != 5) begin
            errors++;
            $display("FAIL two_node_len: got %0d want 5", c);
        end
        cyc();
        checks++;
        if (m2x[1] !== 8'(ex[1]) || m2y[1] !== 8'(ey[1]) || m2x[0] !== 8'd200 || m2y[0] !== 8'd0) begin
            errors++;
            $display("FAIL two_node_pos: got (%0d,%0d)(%0d,%0d) want (200,0)(%0d,%0d)",
                     m2x[0], m2y[0], m2x[1], m2y[1], ex[1], ey[1]);
        end
`ifdef SIM_STATS_EN
        checks++;
        if (fc2 !== 16'd1) begin
            errors++;
            $display("FAIL two_node_frames: got %0d want 1", fc2);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_arith();
        test_frame_random();
        test_frame_random();
        test_directed_pair();
        test_busy_ignore();
        test_reset_midframe();
        test_two_node();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
